// File: rtl/dmem_pkg.sv
// Shared types and funct3 encodings for the data-memory responder.
package dmem_pkg;
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;

   typedef logic [3:0] dmem_be_t;
endpackage

// File: rtl/dmem_lane_align.sv
// RV32I lane steering: store byte enables/shifted data and load extension; combinational.
// Access-fault detection is present only when BUS_ERR_EN is defined.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output dmem_be_t    be,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata,
   output logic        err
);
   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   always_comb begin
      rbyte      = rword[{addr_lo, 3'b000} +: 8];
      rhalf      = rword[{addr_lo[1], 4'b0000} +: 16];
      be         = '0;
      wdata_lane = '0;
      rdata      = '0;
      if (we) begin
         // Replicating the data lets the byte enables pick the lane.
         case (funct3)
            SB: begin
               be         = dmem_be_t'(4'b0001 << addr_lo);
               wdata_lane = {4{wdata[7:0]}};
            end
            SH: begin
               be         = addr_lo[1] ? 4'b1100 : 4'b0011;
               wdata_lane = {2{wdata[15:0]}};
            end
            SW: begin
               be         = 4'b1111;
               wdata_lane = wdata;
            end
            default: ;
         endcase
      end else begin
         case (funct3)
            LB:      rdata = {{24{rbyte[7]}}, rbyte};
            LH:      rdata = {{16{rhalf[15]}}, rhalf};
            LW:      rdata = rword;
            LBU:     rdata = {24'd0, rbyte};
            LHU:     rdata = {16'd0, rhalf};
            default: rdata = '0;
         endcase
      end
   end

`ifdef BUS_ERR_EN
   always_comb begin
      case (funct3)
         LB:      err = 1'b0;
         LH:      err = addr_lo[0];
         LW:      err = (addr_lo != 2'b00);
         LBU:     err = we;
         LHU:     err = we | addr_lo[0];
         default: err = 1'b1;
      endcase
   end
`else
   assign err = 1'b0;
`endif
endmodule

// File: rtl/data_mem_responder.sv
// RV32I data-memory responder: IDLE -> WAIT x WAIT_CYCLES -> RESP, one access per WAIT_CYCLES+2 cycles.
// busReady pulses for one cycle in RESP; BUS_ERR_EN enables access-fault reporting on busErr.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        busReq,
   input  logic        busWe,
   input  logic [2:0]  busFunct3,
   input  logic [31:0] busAddr,
   input  logic [31:0] busWData,
   output logic [31:0] busRData,
   output logic        busReady,
   output logic        busErr
);
   localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
   localparam int DEPTH = 2**ADDR_WIDTH;

   dmem_state_e           state;
   logic [3:0]            cnt;
   logic                  we_q;
   logic [2:0]            funct3_q;
   logic [ADDR_WIDTH+1:0] addr_q;
   logic [31:0]           wdata_q;
   logic [31:0]           mem [DEPTH];

   logic                  idle;
   logic                  enter_resp;
   logic                  acc_we;
   logic [2:0]            acc_funct3;
   logic [ADDR_WIDTH+1:0] acc_addr;
   logic [31:0]           acc_wdata;
   logic [ADDR_WIDTH-1:0] acc_idx;
   dmem_be_t              be;
   logic [31:0]           wdata_lane;
   logic [31:0]           rdata;
   logic                  err;
   logic                  unused_addr_hi;

   assign unused_addr_hi = ^busAddr[31:ADDR_WIDTH+2];

   // With zero wait states the access happens on the acceptance edge, so use the live bus.
   assign idle       = (state == IDLE);
   assign acc_we     = idle ? busWe     : we_q;
   assign acc_funct3 = idle ? busFunct3 : funct3_q;
   assign acc_addr   = idle ? busAddr[ADDR_WIDTH+1:0] : addr_q;
   assign acc_wdata  = idle ? busWData  : wdata_q;
   assign acc_idx    = acc_addr[ADDR_WIDTH+1:2];
   assign enter_resp = (idle && busReq && (WAIT_CYCLES == 0)) ||
                       ((state == WAIT) && (cnt == WAIT_LAST));

   dmem_lane_align u_align (
      .we         (acc_we),
      .funct3     (acc_funct3),
      .addr_lo    (acc_addr[1:0]),
      .wdata      (acc_wdata),
      .rword      (mem[acc_idx]),
      .be         (be),
      .wdata_lane (wdata_lane),
      .rdata      (rdata),
      .err        (err)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         we_q     <= 1'b0;
         funct3_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         busReady <= 1'b0;
         busRData <= '0;
      end else begin
         busReady <= enter_resp;
         if (enter_resp)
            busRData <= err ? '0 : rdata;
         case (state)
            IDLE: if (busReq) begin
               we_q     <= busWe;
               funct3_q <= busFunct3;
               addr_q   <= busAddr[ADDR_WIDTH+1:0];
               wdata_q  <= busWData;
               cnt      <= '0;
               state    <= (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
            WAIT: if (cnt == WAIT_LAST) begin
               cnt   <= '0;
               state <= RESP;
            end else begin
               cnt <= cnt + 4'd1;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && enter_resp && !err)
         for (int i = 0; i < 4; i++)
            if (be[i])
               mem[acc_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
   end

`ifdef BUS_ERR_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         busErr <= 1'b0;
      else
         busErr <= enter_resp & err;
   end
`else
   assign busErr = 1'b0;
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder with a word-array reference model and per-cycle compare.
module tb_data_mem_responder;
   localparam int AW = 10;
   localparam int W  = 1;
`ifdef BUS_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        busReq = 1'b0;
   logic        busWe = 1'b0;
   logic [2:0]  busFunct3 = '0;
   logic [31:0] busAddr = '0;
   logic [31:0] busWData = '0;
   logic [31:0] busRData;
   logic        busReady;
   logic        busErr;

   data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .busReq    (busReq),
      .busWe     (busWe),
      .busFunct3 (busFunct3),
      .busAddr   (busAddr),
      .busWData  (busWData),
      .busRData  (busRData),
      .busReady  (busReady),
      .busErr    (busErr)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        expq[$];
   logic [31:0] mem_m [1024];
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;
   int          ready_cnt = 0;
   int          last_ready_cyc = 0;
   int          acc_cyc = 0;
   logic [31:0] last_rdata = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: byte-addressed semantics on a word array.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err);
      int          idx, bs, hs;
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      idx = int'((addr >> 2) % 1024);
      bs  = 8 * int'(addr % 4);
      hs  = 16 * int'((addr % 4) / 2);
      w   = mem_m[idx];
      b   = w[bs +: 8];
      h   = w[hs +: 16];
      case (f3)
         3'b000:  err = 1'b0;
         3'b001:  err = addr[0];
         3'b010:  err = (addr % 4) != 0;
         3'b100:  err = we;
         3'b101:  err = we | addr[0];
         default: err = 1'b1;
      endcase
      err = err & ERR_EN;
      rd  = '0;
      if (!err) begin
         if (we) begin
            case (f3)
               3'b000:  w[bs +: 8]  = wd[7:0];
               3'b001:  w[hs +: 16] = wd[15:0];
               3'b010:  w = wd;
               default: ;
            endcase
            mem_m[idx] = w;
         end else begin
            case (f3)
               3'b000:  rd = {{24{b[7]}}, b};
               3'b001:  rd = {{16{h[15]}}, h};
               3'b010:  rd = w;
               3'b100:  rd = {24'd0, b};
               3'b101:  rd = {16'd0, h};
               default: rd = '0;
            endcase
         end
      end
   endtask

   // Compare process: every cycle, busReady must match the expected schedule.
   always @(negedge clk) begin
      if (busReady === 1'b1) begin
         ready_cnt++;
         last_ready_cyc = cyc;
         last_rdata     = busRData;
      end
      if (expq.size() > 0 && expq[0].due == cyc) begin
         chk("ready", 32'(busReady), 32'd1);
         chk("rdata", busRData, expq[0].rdata);
         chk("err", 32'(busErr), 32'(expq[0].err));
         void'(expq.pop_front());
      end else begin
         chk("ready_low", 32'(busReady), 32'd0);
      end
   end

   task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      exp_t        e;
      logic [31:0] rd;
      logic        er;
      model(we, f3, addr, wd, rd, er);
      e.due = cyc + 1 + W;
      e.rdata = rd;
      e.err = er;
      expq.push_back(e);
      busReq = 1'b1; busWe = we; busFunct3 = f3; busAddr = addr; busWData = wd;
      @(posedge clk); #1;
      acc_cyc = cyc;
      busReq = 1'b0;
      busWe = 1'($urandom); busFunct3 = 3'($urandom); busAddr = $urandom; busWData = $urandom;
      repeat (W + 1) @(posedge clk);
      #1;
   endtask

   // busReq held high across two full access periods: exactly two responses.
   task automatic hold_lw(input logic [31:0] addr);
      exp_t        e;
      logic [31:0] rd;
      logic        er;
      int          k;
      model(1'b0, 3'b010, addr, 32'd0, rd, er);
      k = cyc;
      e.rdata = rd;
      e.err = er;
      e.due = k + 1 + W;
      expq.push_back(e);
      e.due = k + 1 + W + (W + 2);
      expq.push_back(e);
      busReq = 1'b1; busWe = 1'b0; busFunct3 = 3'b010; busAddr = addr; busWData = '0;
      repeat (2 * (W + 2)) @(posedge clk);
      #1;
      busReq = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int r0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_rdata", busRData, 32'd0);
      chk("rst_ready", 32'(busReady), 32'd0);
      chk("rst_err", 32'(busErr), 32'd0);

      for (int i = 0; i < 80; i++)
         txn(1'b1, 3'b010, 32'(i * 4), $urandom);

      txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
      txn(1'b0, 3'b010, 32'h100, 32'd0);
      chk("lw_100", last_rdata, 32'hDEADBEEF);
      chk("ready_latency", 32'(last_ready_cyc - acc_cyc), 32'd1);

      txn(1'b1, 3'b000, 32'h103, 32'h00000080);
      txn(1'b0, 3'b000, 32'h103, 32'd0);
      chk("lb_103", last_rdata, 32'hFFFFFF80);
      txn(1'b0, 3'b100, 32'h103, 32'd0);
      chk("lbu_103", last_rdata, 32'h00000080);
      txn(1'b0, 3'b010, 32'h100, 32'd0);
      chk("lw_after_sb", last_rdata, 32'h80ADBEEF);

      txn(1'b1, 3'b001, 32'h102, 32'h00008001);
      txn(1'b0, 3'b001, 32'h102, 32'd0);
      chk("lh_102", last_rdata, 32'hFFFF8001);
      txn(1'b0, 3'b101, 32'h102, 32'd0);
      chk("lhu_102", last_rdata, 32'h00008001);
      txn(1'b0, 3'b010, 32'hABC00100, 32'd0);
      chk("alias_lw", last_rdata, 32'h8001BEEF);

      txn(1'b1, 3'b010, 32'h101, 32'h12345678);
      txn(1'b0, 3'b010, 32'h100, 32'd0);
      chk("misaligned_sw", last_rdata, ERR_EN ? 32'h8001BEEF : 32'h12345678);

      r0 = ready_cnt;
      hold_lw(32'h100);
      chk("hold_readies", 32'(ready_cnt - r0), 32'd2);

      txn(1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
      r0 = ready_cnt;
      busReq = 1'b1; busWe = 1'b1; busFunct3 = 3'b010; busAddr = 32'h40; busWData = 32'h11223344;
      @(posedge clk); #1;
      busReq = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("mid_wait_rst_rdata", busRData, 32'd0);
      chk("mid_wait_rst_noready", 32'(ready_cnt - r0), 32'd0);
      txn(1'b0, 3'b010, 32'h40, 32'd0);
      chk("mid_wait_rst_ram", last_rdata, 32'hCAFEF00D);

      for (int n = 0; n < 200; n++) begin
         logic [31:0] a;
         a = 32'($urandom_range(0, 319));
         if ($urandom_range(0, 3) == 0)
            a = a | 32'hABC00000;
         txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
      end

      repeat (3) @(posedge clk);
      chk("queue_drained", 32'(expq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
